// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array row feeder: FSM encoding and default tile geometry.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StFeed,
    StDrain
  } state_e;

  localparam int unsigned DefM         = 5;
  localparam int unsigned DefN         = 3;
  localparam int unsigned DefK         = 4;
  localparam int unsigned DefDataWidth = 8;

endpackage

// File: rtl/systolic_feeder_if.sv
// Row-input handshake and skewed output stream of the systolic feeder.
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned N          = DefN
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH*N-1:0] in_row;
  logic [DATA_WIDTH*N-1:0] X;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid,
    output in_row,
    input  in_ready,
    input  X,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_row,
    output in_ready,
    output X,
    output busy,
    output done
  );

endinterface

// File: rtl/feeder_row_buf.sv
// M-entry row register file with one write port and a full combinational read-out.
module feeder_row_buf #(
  parameter int unsigned M          = 5,
  parameter int unsigned N          = 3,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW        = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned RowW      = DATA_WIDTH * N
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [RowW-1:0]        wdata,
  output logic [M-1:0][RowW-1:0] rdata
);

  logic [M-1:0][RowW-1:0] mem;

  // Contents are don't-care until loaded, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/systolic_feeder.sv
// Loads an M-row X tile, streams it (diagonally skewed when FEEDER_SKEW_EN is defined) into a
// systolic array, then drains zeros for DRAIN_CYC cycles and pulses done.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned M          = DefM,
  parameter int unsigned N          = DefN,
  parameter int unsigned K          = DefK,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DRAIN_CYC  = N + K
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus
);

  localparam int unsigned RowW = DATA_WIDTH * N;
  localparam int unsigned RW   = (M > 1) ? $clog2(M) : 1;
`ifdef FEEDER_SKEW_EN
  localparam int unsigned FeedLen = M + N - 1;
`else
  localparam int unsigned FeedLen = M;
`endif
  localparam int unsigned CntMax = (FeedLen > DRAIN_CYC) ? FeedLen : DRAIN_CYC;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  state_e               state_q, state_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RowW-1:0]      x_q, x_d;
  logic                 done_q, done_d;
  logic                 we;
  logic [CW-1:0]        step_sel;
  logic [RowW-1:0]      x_step;
  logic [M-1:0][RowW-1:0] rows_rd, rows_eff;

  assign we = (state_q == StLoad) && bus.in_valid;

  feeder_row_buf #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_row_buf (
    .clk   (clk),
    .we    (we),
    .waddr (row_cnt_q),
    .wdata (bus.in_row),
    .rdata (rows_rd)
  );

  // Step 0 is computed on the edge that writes the last row, so forward the pending write.
  always_comb begin
    rows_eff = rows_rd;
    if (we) begin
      rows_eff[row_cnt_q] = bus.in_row;
    end
  end

  assign step_sel = (state_q == StLoad) ? '0 : cnt_q + 1'b1;

  always_comb begin
    int idx;
    x_step = '0;
`ifdef FEEDER_SKEW_EN
    for (int i = 0; i < int'(N); i++) begin
      idx = int'(step_sel) - i;
      if (idx >= 0 && idx < int'(M)) begin
        x_step[i*DATA_WIDTH +: DATA_WIDTH] = rows_eff[idx[RW-1:0]][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`else
    idx = int'(step_sel);
    if (idx < int'(M)) begin
      x_step = rows_eff[idx[RW-1:0]];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cnt_d     = cnt_q;
    x_d       = '0;
    done_d    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (we) begin
          if (row_cnt_q == RW'(M - 1)) begin
            state_d   = StFeed;
            row_cnt_d = '0;
            cnt_d     = '0;
            x_d       = x_step;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StFeed: begin
        if (cnt_q == CW'(FeedLen - 1)) begin
          cnt_d = '0;
          if (DRAIN_CYC == 0) begin
            state_d = StLoad;
            done_d  = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          x_d   = x_step;
        end
      end
      StDrain: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = StLoad;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StLoad;
      row_cnt_q <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = (state_q == StLoad);
  assign bus.busy     = (state_q != StLoad);
  assign bus.X        = x_q;
  assign bus.done     = done_q;

endmodule
